// File: rtl/pmp_types_pkg.sv
// Shared types and constants for the PMP table loader: FSM states, CSR bases, widths.
package pmp_types_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CFG_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_A,
    FETCH_C,
    WR_ADDR,
    RD_ADDR,
    RD_CFG,
    WR_CFG,
    DONE,
    ERROR
  } pmp_state_e;

endpackage

// File: rtl/priv_pmp_loader.sv
// Walks a region table in memory and programs pmpaddr/pmpcfg CSRs one region at a time,
// honouring locked cfg bytes and flagging WARL readback differences.
module priv_pmp_loader
  import pmp_types_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned TBL_AW      = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [4:0]        num_regions,
  output logic              tbl_req,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic              tbl_valid,
  input  logic [31:0]       tbl_rdata,
  output logic [11:0]       csr_addr,
  output logic              csr_active,
  output logic [31:0]       csr_wdata,
  input  logic [31:0]       csr_rdata,
  input  logic              csr_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        err_index,
  output logic              warl_mismatch,
  output logic              locked_skip
);

  pmp_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [CFG_W-1:0]  cfgb_q, cfgb_d;

  logic              tbl_req_q, tbl_req_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic              csr_active_q, csr_active_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [IDX_W-1:0]  err_index_q, err_index_d;
  logic              warl_q, warl_d;
  logic              locked_q, locked_d;

  logic [4:0]        lane_lsb_c;
  logic              cfg_locked_c;
  logic [XLEN-1:0]   cfg_merged_c;

  // Byte-lane view of the cfg word currently on csr_rdata (valid while in RD_CFG)
  always_comb begin
    lane_lsb_c   = {idx_q[1:0], 3'b000};
    cfg_locked_c = csr_rdata[lane_lsb_c + 5'd7];
    cfg_merged_c = csr_rdata;
    cfg_merged_c[lane_lsb_c +: CFG_W] = cfgb_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    addr_d      = addr_q;
    cfgb_d      = cfgb_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    warl_d      = warl_q;
    locked_d    = locked_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          error_d     = 1'b0;
          err_index_d = '0;
          warl_d      = 1'b0;
          locked_d    = 1'b0;
          count_d     = (num_regions > CNT_W'(NUM_ENTRIES)) ? CNT_W'(NUM_ENTRIES) : num_regions;
          state_d     = (num_regions == '0) ? DONE : FETCH_A;
        end
      end
      FETCH_A: begin
        if (tbl_valid) begin
          addr_d  = tbl_rdata;
          state_d = FETCH_C;
        end
      end
      FETCH_C: begin
        if (tbl_valid) begin
          cfgb_d  = tbl_rdata[CFG_W-1:0];
          state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        if (!csr_ack) begin
          state_d     = ERROR;
          error_d     = 1'b1;
          err_index_d = idx_q;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (csr_rdata != addr_q) begin
          warl_d = 1'b1;
        end
        state_d = RD_CFG;
      end
      RD_CFG: begin
        if (!csr_ack) begin
          state_d     = ERROR;
          error_d     = 1'b1;
          err_index_d = idx_q;
        end else begin
          if (cfg_locked_c) begin
            locked_d = 1'b1;
          end
          state_d = WR_CFG;
        end
      end
      WR_CFG: begin
        if (CNT_W'(idx_q) + CNT_W'(1) == count_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FETCH_A;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the upcoming state so they register in step with it
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    tbl_req_d    = 1'b0;
    tbl_addr_d   = '0;
    csr_addr_d   = '0;
    csr_active_d = 1'b0;
    csr_wdata_d  = '0;

    case (state_d)
      FETCH_A: begin
        tbl_req_d  = 1'b1;
        tbl_addr_d = TBL_AW'({idx_d, 1'b0});
      end
      FETCH_C: begin
        tbl_req_d  = 1'b1;
        tbl_addr_d = TBL_AW'({idx_d, 1'b1});
      end
      WR_ADDR: begin
        csr_addr_d   = PMPADDR_BASE + 12'(idx_d);
        csr_active_d = 1'b1;
        csr_wdata_d  = addr_d;
      end
      RD_ADDR: begin
        csr_addr_d = PMPADDR_BASE + 12'(idx_d);
      end
      RD_CFG: begin
        csr_addr_d = PMPCFG_BASE + 12'(idx_d[3:2]);
      end
      WR_CFG: begin
        // Only reachable from RD_CFG, so the lock/merge view still reflects this region
        csr_addr_d   = PMPCFG_BASE + 12'(idx_d[3:2]);
        csr_active_d = !cfg_locked_c;
        csr_wdata_d  = cfg_locked_c ? '0 : cfg_merged_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      cfgb_q       <= '0;
      tbl_req_q    <= 1'b0;
      tbl_addr_q   <= '0;
      csr_addr_q   <= '0;
      csr_active_q <= 1'b0;
      csr_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_index_q  <= '0;
      warl_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      cfgb_q       <= cfgb_d;
      tbl_req_q    <= tbl_req_d;
      tbl_addr_q   <= tbl_addr_d;
      csr_addr_q   <= csr_addr_d;
      csr_active_q <= csr_active_d;
      csr_wdata_q  <= csr_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_index_q  <= err_index_d;
      warl_q       <= warl_d;
      locked_q     <= locked_d;
    end
  end

  assign tbl_req       = tbl_req_q;
  assign tbl_addr      = tbl_addr_q;
  assign csr_addr      = csr_addr_q;
  assign csr_active    = csr_active_q;
  assign csr_wdata     = csr_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_index_q;
  assign warl_mismatch = warl_q;
  assign locked_skip   = locked_q;

endmodule

// File: tb/tb_priv_pmp_loader.sv
// Bench for priv_pmp_loader: table memory with programmable latency, a PMP CSR responder,
// and a region-by-region reference model of the expected CSR contents and flags.
module tb_priv_pmp_loader;

  localparam int NE  = 16;
  localparam int TAW = 6;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           start = 1'b0;
  logic [4:0]     num_regions = '0;
  logic           tbl_req;
  logic [TAW-1:0] tbl_addr;
  logic           tbl_valid;
  logic [31:0]    tbl_rdata;
  logic [11:0]    csr_addr;
  logic           csr_active;
  logic [31:0]    csr_wdata;
  logic [31:0]    csr_rdata;
  logic           csr_ack;
  logic           busy, done, error;
  logic [3:0]     err_index;
  logic           warl_mismatch, locked_skip;

  always #5 CLK = ~CLK;

  priv_pmp_loader #(.NUM_ENTRIES(NE), .TBL_AW(TAW)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .num_regions(num_regions),
    .tbl_req(tbl_req), .tbl_addr(tbl_addr), .tbl_valid(tbl_valid), .tbl_rdata(tbl_rdata),
    .csr_addr(csr_addr), .csr_active(csr_active), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ack(csr_ack),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .warl_mismatch(warl_mismatch), .locked_skip(locked_skip)
  );

  int n_vec = 0;
  int n_err = 0;

  // Table memory with per-word response latency
  logic [31:0] tbl_mem [64];
  int wait_cnt = 0;
  int cur_dly = 0;
  int dly_sum = 0;
  bit rand_dly = 1'b0;
  int fixed_dly = 0;

  assign tbl_valid = tbl_req && (wait_cnt >= cur_dly);
  assign tbl_rdata = tbl_mem[tbl_addr];

  always @(posedge CLK) begin
    if (tbl_valid) begin
      wait_cnt <= 0;
      dly_sum  <= dly_sum + cur_dly;
      cur_dly  <= rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
    end else if (tbl_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      cur_dly  <= rand_dly ? int'($urandom_range(0, 3)) : fixed_dly;
    end
  end

  // PMP CSR responder
  logic [31:0] rsp_addr [16];
  logic [31:0] rsp_cfg [4];
  logic [31:0] init_addr [16];
  logic [31:0] init_cfg [4];
  bit rsp_load = 1'b0;
  bit warl_en = 1'b0;
  bit nack_en = 1'b0;
  int nack_idx = 0;

  always_comb begin
    csr_ack   = 1'b0;
    csr_rdata = '0;
    if (csr_addr >= 12'h3B0 && csr_addr <= 12'h3BF) begin
      csr_ack   = 1'b1;
      csr_rdata = rsp_addr[csr_addr[3:0]];
    end else if (csr_addr >= 12'h3A0 && csr_addr <= 12'h3A3) begin
      csr_ack   = 1'b1;
      csr_rdata = rsp_cfg[csr_addr[1:0]];
    end
    if (nack_en && csr_active && csr_addr == 12'h3B0 + 12'(nack_idx)) csr_ack = 1'b0;
  end

  always @(posedge CLK) begin
    if (rsp_load) begin
      for (int i = 0; i < 16; i++) rsp_addr[i] <= init_addr[i];
      for (int i = 0; i < 4; i++) rsp_cfg[i] <= init_cfg[i];
    end else if (csr_active && csr_ack) begin
      if (csr_addr >= 12'h3B0) rsp_addr[csr_addr[3:0]] <= warl_en ? (csr_wdata & ~32'h1) : csr_wdata;
      else rsp_cfg[csr_addr[1:0]] <= csr_wdata;
    end
  end

  // Reference model results
  logic [31:0] exp_addr [16];
  logic [31:0] exp_cfg [4];
  bit exp_warl, exp_locked, exp_err;
  int exp_err_idx, exp_writes, exp_n;

  // Run results
  int r_lat, r_wr, r_max, r_bad, r_dsum;
  bit r_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_run(input int n_req);
    int n;
    logic [31:0] a, w, cur;
    int lane;
    n = (n_req > NE) ? NE : n_req;
    exp_n = n;
    exp_addr = init_addr;
    exp_cfg = init_cfg;
    exp_warl = 1'b0; exp_locked = 1'b0; exp_err = 1'b0; exp_err_idx = 0; exp_writes = 0;
    for (int i = 0; i < n; i++) begin
      exp_writes++;
      if (nack_en && i == nack_idx) begin
        exp_err = 1'b1;
        exp_err_idx = i;
        break;
      end
      a = warl_en ? (tbl_mem[2*i] & ~32'h1) : tbl_mem[2*i];
      exp_addr[i] = a;
      if (a != tbl_mem[2*i]) exp_warl = 1'b1;
      lane = i % 4;
      w = exp_cfg[i/4];
      cur = (w >> (8*lane)) & 32'hFF;
      if (cur >= 32'h80) begin
        exp_locked = 1'b1;
      end else begin
        w = (w & ~(32'hFF << (8*lane))) | ((tbl_mem[2*i+1] & 32'hFF) << (8*lane));
        exp_cfg[i/4] = w;
        exp_writes++;
      end
    end
  endtask

  task automatic setup(input bit warl, input bit nack, input int nidx, input bit rdly, input int fdly);
    warl_en = warl; nack_en = nack; nack_idx = nidx; rand_dly = rdly; fixed_dly = fdly;
    @(negedge CLK); rsp_load = 1'b1;
    @(negedge CLK); rsp_load = 1'b0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) tbl_mem[i] = $urandom;
    for (int i = 0; i < 16; i++) init_addr[i] = $urandom;
    for (int i = 0; i < 4; i++) init_cfg[i] = 32'h0;
  endtask

  task automatic run_load(input int n_req, input bit glitch);
    int base;
    bit fin;
    @(negedge CLK);
    start = 1'b1;
    num_regions = 5'(n_req);
    base = dly_sum;
    r_lat = 0; r_done = 1'b0; r_wr = 0; r_max = -1; r_bad = 0; fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge CLK);
      if (k == 0) start = 1'b0;
      if (glitch && k == 2) begin start = 1'b1; num_regions = 5'd0; end
      if (glitch && k == 3) start = 1'b0;
      if (csr_active) begin
        r_wr++;
        if (!((csr_addr >= 12'h3B0 && csr_addr <= 12'h3BF) ||
              (csr_addr >= 12'h3A0 && csr_addr <= 12'h3A3))) r_bad++;
      end
      if (csr_addr >= 12'h3B0 && csr_addr <= 12'h3BF && int'(csr_addr[3:0]) > r_max)
        r_max = int'(csr_addr[3:0]);
      if (done) begin
        r_done = 1'b1;
        r_lat = k;
        fin = 1'b1;
      end else if (error) begin
        fin = 1'b1;
      end
    end
    r_dsum = dly_sum - base;
    check("run_terminated", 32'(fin), 32'd1);
    @(negedge CLK);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_run", 32'(busy), 32'd0);
  endtask

  task automatic run_and_check(input int n_req, input bit glitch);
    model_run(n_req);
    run_load(n_req, glitch);
    check("done_seen", 32'(r_done), 32'(!exp_err));
    if (!exp_err) check("latency", r_lat, 6*exp_n + r_dsum);
    check("error", 32'(error), 32'(exp_err));
    if (exp_err) check("err_index", 32'(err_index), exp_err_idx);
    check("warl_mismatch", 32'(warl_mismatch), 32'(exp_warl));
    check("locked_skip", 32'(locked_skip), 32'(exp_locked));
    check("csr_strobes", r_wr, exp_writes);
    check("strobe_addr_range", r_bad, 0);
    check("max_region", r_max, exp_err ? exp_err_idx : exp_n - 1);
    for (int i = 0; i < 16; i++) check($sformatf("pmpaddr%0d", i), rsp_addr[i], exp_addr[i]);
    for (int i = 0; i < 4; i++) check($sformatf("pmpcfg%0d", i), rsp_cfg[i], exp_cfg[i]);
  endtask

  initial begin
    int cfgw;
    bit hit;

    // Reset state
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tbl_req", 32'(tbl_req), 32'd0);
    check("rst_csr_addr", 32'(csr_addr), 32'd0);
    check("rst_csr_active", 32'(csr_active), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    nRST = 1'b1;

    // Single region, immediate table responses
    fill_rand();
    tbl_mem[0] = 32'h2000_0000;
    tbl_mem[1] = 32'h0000_001F;
    setup(1'b0, 1'b0, 0, 1'b0, 0);
    run_and_check(1, 1'b0);
    check("single_latency", r_lat, 6);
    check("single_pmpaddr0", rsp_addr[0], 32'h2000_0000);
    check("single_pmpcfg0", rsp_cfg[0], 32'h0000_001F);

    // Six regions, three-cycle table latency, partial pmpcfg1 update
    fill_rand();
    init_cfg[1] = 32'h3355_0000;
    setup(1'b0, 1'b0, 0, 1'b0, 3);
    run_and_check(6, 1'b0);
    check("six_latency", r_lat, 72);
    check("six_cfg1_lane0", 32'(rsp_cfg[1][7:0]), tbl_mem[9] & 32'hFF);
    check("six_cfg1_lane1", 32'(rsp_cfg[1][15:8]), tbl_mem[11] & 32'hFF);
    check("six_cfg1_upper", 32'(rsp_cfg[1][31:16]), 32'h3355);

    // Region 2 cfg byte pre-locked
    fill_rand();
    init_cfg[0] = 32'h0080_0000;
    setup(1'b0, 1'b0, 0, 1'b0, 0);
    run_and_check(4, 1'b0);
    check("lock_flag", 32'(locked_skip), 32'd1);
    check("lock_strobes", r_wr, 7);
    check("lock_lane2", 32'(rsp_cfg[0][23:16]), 32'h80);

    // WARL responder drops address bit 0
    fill_rand();
    tbl_mem[0] = tbl_mem[0] | 32'h1;
    setup(1'b1, 1'b0, 0, 1'b0, 1);
    run_and_check(3, 1'b0);
    check("warl_flag", 32'(warl_mismatch), 32'd1);
    check("warl_no_error", 32'(error), 32'd0);
    check("warl_done", 32'(r_done), 32'd1);

    // Unclaimed pmpaddr3 write, then recovery on the next start
    fill_rand();
    setup(1'b0, 1'b1, 3, 1'b0, 0);
    run_and_check(5, 1'b0);
    check("nack_error", 32'(error), 32'd1);
    check("nack_index", 32'(err_index), 32'd3);
    check("nack_no_done", 32'(r_done), 32'd0);
    setup(1'b0, 1'b0, 0, 1'b0, 0);
    run_and_check(1, 1'b0);
    check("nack_cleared", 32'(error), 32'd0);

    // Randomized loads, including clamped counts, stray starts and nacks
    for (int it = 0; it < 12; it++) begin
      int n;
      fill_rand();
      for (int c = 0; c < 4; c++) begin
        for (int b = 0; b < 4; b++) begin
          logic [31:0] byt;
          byt = ($urandom & 32'h7F) | (($urandom_range(0, 3) == 0) ? 32'h80 : 32'h0);
          init_cfg[c] = init_cfg[c] | (byt << (8*b));
        end
      end
      n = int'($urandom_range(0, 20));
      setup(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), 1'b1, 0);
      run_and_check(n, n > 0);
    end

    // Reset while region 1 writes its cfg word
    fill_rand();
    setup(1'b0, 1'b0, 0, 1'b0, 0);
    @(negedge CLK);
    start = 1'b1;
    num_regions = 5'd4;
    cfgw = 0;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge CLK);
      if (k == 0) start = 1'b0;
      if (csr_active && csr_addr == 12'h3A0) cfgw++;
      if (cfgw == 2) hit = 1'b1;
    end
    check("midrst_reached", 32'(hit), 32'd1);
    nRST = 1'b0;
    @(negedge CLK);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tbl_req", 32'(tbl_req), 32'd0);
    check("midrst_tbl_addr", 32'(tbl_addr), 32'd0);
    check("midrst_csr_addr", 32'(csr_addr), 32'd0);
    check("midrst_csr_active", 32'(csr_active), 32'd0);
    check("midrst_csr_wdata", csr_wdata, 32'd0);
    check("midrst_flags", {28'd0, done, error, warl_mismatch, locked_skip}, 32'd0);
    check("midrst_err_index", 32'(err_index), 32'd0);
    nRST = 1'b1;
    start = 1'b1;
    num_regions = 5'd0;
    @(negedge CLK);
    start = 1'b0;
    check("zero_regions_done", 32'(done), 32'd1);
    @(negedge CLK);
    check("zero_regions_pulse", 32'(done), 32'd0);
    check("zero_regions_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priv_pmp_loader.md
PRIV_PMP_LOADER -- requirements
Module: priv_pmp_loader

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, meaning the maximum number of PMP regions programmable (1..16).
REQ-002 SHALL have parameter TBL_AW, default 6, meaning the table word-address width.
REQ-003 SHALL have clock and reset ports CLK and nRST: one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports, each as name, direction, width, meaning:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- start  in  1  begin a load sequence; sampled only in IDLE.
- num_regions  in  5  regions to load (0..NUM_ENTRIES); sampled with start.
- tbl_req  out  1  table read request.
- tbl_addr  out  TBL_AW  table word address.
- tbl_valid  in  1  tbl_rdata valid.
- tbl_rdata  in  32  table word.
- csr_addr  out  12  CSR address to the extension responder.
- csr_active  out  1  CSR write strobe.
- csr_wdata  out  32  CSR write data.
- csr_rdata  in  32  responder read data.
- csr_ack  in  1  responder claims csr_addr.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky failure flag.
- err_index  out  4  region index at failure.
- warl_mismatch  out  1  sticky: a pmpaddr readback differed from the written value.
- locked_skip  out  1  sticky: at least one cfg byte was skipped because it was locked.

Function
REQ-005 Table layout SHALL be, for region i: word 2i = pmpaddr value, word 2i+1 bits[7:0] = pmpcfg byte, with bits[31:8] ignored.
REQ-006 States SHALL be IDLE, FETCH_A, FETCH_C, WR_ADDR, RD_ADDR, RD_CFG, WR_CFG, DONE, ERROR.
REQ-007 IDLE + start SHALL enter FETCH_A with i=0, clear error/warl_mismatch/locked_skip, and latch num_regions clamped to NUM_ENTRIES; if num_regions=0 it SHALL enter DONE instead.
REQ-008 Table fetch SHALL work as follows:
- FETCH_A/FETCH_C hold tbl_req=1 and tbl_addr=2i or 2i+1, stable until tbl_valid.
- tbl_valid may assert in the same cycle as the request.
- The state advances on the tbl_valid cycle, capturing tbl_rdata.
REQ-009 WR_ADDR SHALL drive csr_addr=0x3B0+i, csr_wdata=captured address, and csr_active=1 for exactly one cycle.
- If csr_ack=0 that cycle, go to ERROR.
REQ-010 RD_ADDR SHALL drive csr_addr=0x3B0+i with csr_active=0 and compare csr_rdata with the written value.
- On mismatch, set warl_mismatch; this is not an error.
REQ-011 RD_CFG SHALL drive csr_addr=0x3A0+(i>>2) with csr_active=0 and capture csr_rdata as the current cfg word.
- If csr_ack=0, go to ERROR.
REQ-012 WR_CFG SHALL handle the cfg byte as follows:
- If lane (i&3) of the captured cfg word has bit 7 (L) set: skip the write (csr_active=0) and set locked_skip.
- Otherwise: write the captured cfg word with lane (i&3) replaced by the table cfg byte, all other lanes preserved, csr_active=1 for one cycle.
REQ-013 After WR_CFG, if i+1 = latched count the block SHALL enter DONE; otherwise it SHALL increment i and enter FETCH_A.
REQ-014 Minimum cost SHALL be 6 cycles per region.
REQ-015 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-016 ERROR SHALL set error=1 and err_index=i, then return to IDLE next cycle; error stays set until the next accepted start.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 start while not in IDLE SHALL be ignored.
REQ-019 csr_active SHALL never assert outside WR_ADDR/WR_CFG.
REQ-020 csr_addr SHALL be 0 in IDLE, DONE and ERROR.

Reset
REQ-021 nRST=0 at a clock edge SHALL force IDLE and zero every output and internal register, including mid-sequence; no partial write SHALL be issued in the reset cycle.

Structure
REQ-022 The state enum and the CSR base constants (PMPCFG_BASE=0x3A0, PMPADDR_BASE=0x3B0) SHALL live in pmp_types_pkg.
REQ-023 The block SHALL contain no sub-module; the byte-lane merge is inline.

Verification
REQ-024 num_regions=1, addr word 0x2000_0000, cfg 0x1F, same-cycle tbl_valid, responder with cfg initially 0:
- pmpaddr0=0x2000_0000 and pmpcfg0=0x0000_001F.
- done pulses 6 cycles after start.
REQ-025 num_regions=6 with tbl_valid delayed 3 cycles per word:
- pmpcfg1 lanes 0-1 are written and lanes 2-3 preserved.
- i never exceeds 5.
- Total latency is 6*(6+6)=72 cycles.
REQ-026 Region 2 cfg byte pre-locked (0x80 in lane 2):
- locked_skip=1.
- No csr_active in that WR_CFG.
- pmpcfg0 lane 2 is unchanged.
REQ-027 Responder returns addr&~0x1 (WARL):
- warl_mismatch=1, error=0, done pulses.
REQ-028 csr_ack=0 during region 3 WR_ADDR:
- error=1, err_index=3, no done.
- The next start clears error.
REQ-029 nRST low during WR_CFG of region 1:
- All outputs are 0 next cycle and state is IDLE.
- num_regions=0 with start then gives done the following cycle.
